msx_bus_transaction: RTL and testbench
======================================

Name: msx_bus_transaction

Overview:
- Consumes the filtered, resynchronised MSX cartridge bus signals from the board bus front-end.
- Turns each qualified slot-memory or I/O cycle into exactly one request on a valid/ready backend port (mapper, SDRAM, sound-chip registers).
- Holds the Z80 with WAIT until read data returns, then drives data and BUSDIR back towards the front-end.
- Sits between the board bus block and the cartridge function cores.

Parameters:
- IO_BASE, 8'h7C, I/O port match value (compared against ADDR[7:0])
- IO_MASK, 8'hFE, I/O port match mask; match when (ADDR[7:0] & IO_MASK) == IO_BASE
- TIMEOUT_CYCLES, 1023, read-response watchdog limit in CLK cycles (used only with MSX_BUS_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous active-low reset
- BUS_ADDR  in  16  filtered address
- BUS_DIN  in  8  filtered write data
- BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_M1_n, BUS_RFSH_n  in  1 each  filtered control
- BUS_RD_n, BUS_WR_n  in  1 each  filtered, delayed strobes
- BUS_DOUT  out  8  read data towards cartridge
- BUS_BUSDIR_n  out  1  low = block drives the data bus
- BUS_WAIT_n  out  1  low = insert Z80 wait
- REQ_VALID  out  1  backend request valid
- REQ_READY  in  1  backend accepts
- REQ_WR  out  1  1 = write, 0 = read
- REQ_IO  out  1  1 = I/O cycle, 0 = memory cycle
- REQ_ADDR  out  16  captured address
- REQ_WDATA  out  8  captured write data
- RSP_VALID  in  1  one-cycle read-data strobe
- RSP_RDATA  in  8  read data

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous, active-low on RESET_n.
- Reset values: REQ_VALID=0, REQ_WR=0, REQ_IO=0, REQ_ADDR=0, REQ_WDATA=0, BUS_DOUT=8'hFF, BUS_BUSDIR_n=1, BUS_WAIT_n=1, state=IDLE, strobe history=1.
- Strobe edges: RD_n and WR_n are registered each cycle. A trigger is a 1→0 edge of exactly one of them. Both low in the same cycle → no trigger.
- Memory qualifier: SLTSL_n=0, MERQ_n=0, RFSH_n=1.
- I/O qualifier: IORQ_n=0, M1_n=1, port match. An interrupt-acknowledge cycle (IORQ_n=0, M1_n=0) is ignored.
- Triggers are accepted only in IDLE; other states ignore them.
- State machine:
  - IDLE: on a qualified trigger, latch ADDR, DIN, WR, IO into REQ_* and set REQ_VALID=1 in the next cycle (latency 1). For reads, BUS_WAIT_n=0 in the same cycle REQ_VALID rises. Go to ISSUE.
  - ISSUE: REQ_VALID and all REQ_* fields stay stable until REQ_READY=1; the handshake completes in that cycle. Write → REQ_VALID=0, go to HOLD (writes never assert WAIT). Read → REQ_VALID=0, go to RSPW.
  - RSPW: wait for RSP_VALID. On RSP_VALID, BUS_DOUT<=RSP_RDATA and BUS_WAIT_n<=1, go to HOLD. RSP_VALID arriving in the same cycle as REQ_READY is legal; capture it and go straight to HOLD.
  - HOLD: for reads, BUS_BUSDIR_n=0 while BUS_RD_n=0. When the active strobe returns high, BUS_BUSDIR_n=1 and go to IDLE. The next cycle can trigger from IDLE on its first falling edge.
- Aborts: if RD_n rises during ISSUE or RSPW (bus abort), the handshake still completes and the response is discarded. BUS_BUSDIR_n stays 1, then IDLE.
- Stray responses: RSP_VALID outside RSPW is ignored.
- Reset mid-operation: all outputs return to reset values immediately; no request is pending afterwards.

Optional Feature:
- Macro: MSX_BUS_TIMEOUT_EN.
- When defined: a 10-bit counter clears on entry to ISSUE for reads and increments in ISSUE and RSPW. When it reaches TIMEOUT_CYCLES:
  - BUS_DOUT=8'hFF and BUS_WAIT_n=1.
  - REQ_VALID is held until REQ_READY (the handshake is never broken), and the eventual response is discarded.
  - The block moves to HOLD once the handshake has completed.
- When undefined: no counter; WAIT is held indefinitely until RSP_VALID.

Test Plan:
- Memory read: SLTSL_n=0, MERQ_n=0, ADDR=16'h4000, RD_n falls; backend READY after 2 cycles, RSP_VALID 3 cycles later with 8'hA5 → exactly one REQ (WR=0, IO=0, ADDR=16'h4000); WAIT_n low from REQ_VALID rise until RSP; BUS_DOUT=8'hA5; BUSDIR_n low until RD_n high.
- I/O write: IORQ_n=0, M1_n=1, ADDR[7:0]=8'h7D, DIN=8'h3C, WR_n falls; READY held low 5 cycles → REQ_VALID stable 5 cycles with WDATA=8'h3C, IO=1; WAIT_n stays 1; BUSDIR_n stays 1.
- Filtering, each → no REQ_VALID:
  - I/O port 8'h7E.
  - RFSH_n=0 memory cycle.
  - SLTSL_n=1.
  - M1_n=0 with IORQ_n=0.
  - RD_n and WR_n falling together.
- Back-to-back: two memory reads separated by 1 idle bus cycle, READY tied 1, RSP next cycle → two requests in order, no lost trigger.
- Reset: assert RESET_n low while in RSPW → WAIT_n=1, REQ_VALID=0, BUS_DOUT=8'hFF asynchronously; a late RSP_VALID after release is ignored.
- MSX_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=16, backend never responds → WAIT_n returns high 16 cycles after the counter starts and BUS_DOUT=8'hFF; without the macro WAIT_n stays low.

Source files
------------

// File: rtl/msx_bus_transaction.sv
// MSX cartridge bus transaction engine: turns qualified slot-memory / I/O strobes into
// single valid/ready backend requests and holds WAIT until read data returns.
// Optional read-response watchdog enabled with `define MSX_BUS_TIMEOUT_EN.
module msx_bus_transaction #(
  parameter logic [7:0]  IO_BASE        = 8'h7C,
  parameter logic [7:0]  IO_MASK        = 8'hFE,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [15:0] BUS_ADDR,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_SLTSL_n,
  input  logic        BUS_MERQ_n,
  input  logic        BUS_IORQ_n,
  input  logic        BUS_M1_n,
  input  logic        BUS_RFSH_n,
  input  logic        BUS_RD_n,
  input  logic        BUS_WR_n,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_BUSDIR_n,
  output logic        BUS_WAIT_n,
  output logic        REQ_VALID,
  input  logic        REQ_READY,
  output logic        REQ_WR,
  output logic        REQ_IO,
  output logic [15:0] REQ_ADDR,
  output logic [7:0]  REQ_WDATA,
  input  logic        RSP_VALID,
  input  logic [7:0]  RSP_RDATA
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RSPW  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rd_d, r_wr_d;
  logic          r_req_valid, w_req_valid_nxt;
  logic          r_req_wr, w_req_wr_nxt;
  logic          r_req_io, w_req_io_nxt;
  logic [AW-1:0] r_req_addr, w_req_addr_nxt;
  logic [DW-1:0] r_req_wdata, w_req_wdata_nxt;
  logic [DW-1:0] r_dout, w_dout_nxt;
  logic          r_busdir_n, w_busdir_n_nxt;
  logic          r_wait_n, w_wait_n_nxt;
  logic          r_abort, w_abort_nxt;

  logic w_trig_rd, w_trig_wr, w_mem_q, w_io_q, w_qual;
  logic w_abort, w_strobe_n, w_hs_done;
  logic w_tmo_hit, w_tmo_any;

  // Exactly one strobe falling while the other stays high is a trigger
  assign w_trig_rd = r_rd_d & ~BUS_RD_n & BUS_WR_n;
  assign w_trig_wr = r_wr_d & ~BUS_WR_n & BUS_RD_n;
  assign w_mem_q   = ~BUS_SLTSL_n & ~BUS_MERQ_n & BUS_RFSH_n;
  assign w_io_q    = ~BUS_IORQ_n & BUS_M1_n & ((BUS_ADDR[7:0] & IO_MASK) == IO_BASE);
  assign w_qual    = (w_trig_rd | w_trig_wr) & (w_mem_q | w_io_q);

  assign w_abort    = r_abort | (~r_req_wr & BUS_RD_n);
  assign w_strobe_n = r_req_wr ? BUS_WR_n : BUS_RD_n;
  assign w_hs_done  = (r_state == S_RSPW) | REQ_READY;

`ifdef MSX_BUS_TIMEOUT_EN
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_tmo, w_tmo_nxt;

  assign w_tmo_hit = ((r_state == S_ISSUE) || (r_state == S_RSPW)) && !r_req_wr && !r_tmo &&
                     (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_any = r_tmo | w_tmo_hit;

  // Watchdog counter: cleared while idle, runs across ISSUE and RSPW
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tmo_nxt = r_tmo;
    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      w_tmo_nxt = 1'b0;
    end else if ((r_state == S_ISSUE) || (r_state == S_RSPW)) begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (w_tmo_hit) w_tmo_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tmo <= w_tmo_nxt;
    end
  end
`else
  logic w_unused_tmo;
  assign w_tmo_hit    = 1'b0;
  assign w_tmo_any    = 1'b0;
  assign w_unused_tmo = ^CW'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_req_valid_nxt = r_req_valid;
    w_req_wr_nxt    = r_req_wr;
    w_req_io_nxt    = r_req_io;
    w_req_addr_nxt  = r_req_addr;
    w_req_wdata_nxt = r_req_wdata;
    w_dout_nxt      = r_dout;
    w_busdir_n_nxt  = r_busdir_n;
    w_wait_n_nxt    = r_wait_n;
    w_abort_nxt     = r_abort;

    unique case (r_state)
      S_IDLE: begin
        if (w_qual) begin
          w_req_valid_nxt = 1'b1;
          w_req_wr_nxt    = w_trig_wr;
          w_req_io_nxt    = w_io_q & ~w_mem_q;
          w_req_addr_nxt  = BUS_ADDR;
          w_req_wdata_nxt = BUS_DIN;
          w_wait_n_nxt    = w_trig_wr;
          w_abort_nxt     = 1'b0;
          w_state_nxt     = S_ISSUE;
        end
      end

      S_ISSUE, S_RSPW: begin
        w_abort_nxt = w_abort;
        if (w_abort || w_tmo_hit) w_wait_n_nxt = 1'b1;
        if (w_tmo_hit) w_dout_nxt = 8'hFF;
        if ((r_state == S_ISSUE) && REQ_READY) w_req_valid_nxt = 1'b0;
        if (w_hs_done) begin
          if (r_req_wr) begin
            w_state_nxt = S_HOLD;
          end else if (w_abort) begin
            // Drain the pending response so it cannot be credited to a later cycle
            w_state_nxt = (RSP_VALID || w_tmo_any) ? S_IDLE : S_RSPW;
          end else if (w_tmo_any) begin
            w_busdir_n_nxt = 1'b0;
            w_state_nxt    = S_HOLD;
          end else if (RSP_VALID) begin
            w_dout_nxt     = RSP_RDATA;
            w_wait_n_nxt   = 1'b1;
            w_busdir_n_nxt = 1'b0;
            w_state_nxt    = S_HOLD;
          end else begin
            w_state_nxt = S_RSPW;
          end
        end
      end

      S_HOLD: begin
        if (w_strobe_n) begin
          w_busdir_n_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= S_IDLE;
      r_rd_d      <= 1'b1;
      r_wr_d      <= 1'b1;
      r_req_valid <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_io    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_dout      <= 8'hFF;
      r_busdir_n  <= 1'b1;
      r_wait_n    <= 1'b1;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_d      <= BUS_RD_n;
      r_wr_d      <= BUS_WR_n;
      r_req_valid <= w_req_valid_nxt;
      r_req_wr    <= w_req_wr_nxt;
      r_req_io    <= w_req_io_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_wdata <= w_req_wdata_nxt;
      r_dout      <= w_dout_nxt;
      r_busdir_n  <= w_busdir_n_nxt;
      r_wait_n    <= w_wait_n_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  assign REQ_VALID    = r_req_valid;
  assign REQ_WR       = r_req_wr;
  assign REQ_IO       = r_req_io;
  assign REQ_ADDR     = r_req_addr;
  assign REQ_WDATA    = r_req_wdata;
  assign BUS_DOUT     = r_dout;
  assign BUS_BUSDIR_n = r_busdir_n;
  assign BUS_WAIT_n   = r_wait_n;

endmodule

// File: tb/tb_msx_bus_transaction.sv
// Scoreboard bench for msx_bus_transaction: expected backend requests are queued as
// bus strobes are driven and compared at each valid/ready handshake.
module tb_msx_bus_transaction;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DIN;
  logic        BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_M1_n, BUS_RFSH_n;
  logic        BUS_RD_n, BUS_WR_n;
  logic [7:0]  BUS_DOUT;
  logic        BUS_BUSDIR_n, BUS_WAIT_n;
  logic        REQ_VALID, REQ_READY, REQ_WR, REQ_IO;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;

  typedef struct packed {
    logic        wr;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t q[$];
  req_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k;
  logic [7:0] exp_dout;

  msx_bus_transaction #(
    .IO_BASE(8'h7C), .IO_MASK(8'hFE), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN),
    .BUS_SLTSL_n(BUS_SLTSL_n), .BUS_MERQ_n(BUS_MERQ_n), .BUS_IORQ_n(BUS_IORQ_n),
    .BUS_M1_n(BUS_M1_n), .BUS_RFSH_n(BUS_RFSH_n), .BUS_RD_n(BUS_RD_n), .BUS_WR_n(BUS_WR_n),
    .BUS_DOUT(BUS_DOUT), .BUS_BUSDIR_n(BUS_BUSDIR_n), .BUS_WAIT_n(BUS_WAIT_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR), .REQ_IO(REQ_IO),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    BUS_ADDR = 16'h0000; BUS_DIN = 8'h00;
    BUS_SLTSL_n = 1'b1; BUS_MERQ_n = 1'b1; BUS_IORQ_n = 1'b1;
    BUS_M1_n = 1'b1; BUS_RFSH_n = 1'b1; BUS_RD_n = 1'b1; BUS_WR_n = 1'b1;
  endtask

  // Handshake monitor: every accepted request must match the head of the queue
  always @(negedge CLK) begin
    if (RESET_n && REQ_VALID && REQ_READY) begin
      if (q.size() == 0) begin
        chk("req_unexpected", 32'(1), 32'(0));
      end else begin
        mon_e = q.pop_front();
        chk("req_wr", 32'(REQ_WR), 32'(mon_e.wr));
        chk("req_io", 32'(REQ_IO), 32'(mon_e.io));
        chk("req_addr", 32'(REQ_ADDR), 32'(mon_e.addr));
        if (mon_e.wr) chk("req_wdata", 32'(REQ_WDATA), 32'(mon_e.wdata));
      end
    end
  end

  task automatic mem_read_fast(input logic [15:0] a, input logic [7:0] d, input bit same);
    BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_ADDR = a; BUS_RD_n = 1'b0;
    q.push_back('{1'b0, 1'b0, a, BUS_DIN});
    step();
    chk("b2b_valid", 32'(REQ_VALID), 32'(1));
    chk("b2b_wait", 32'(BUS_WAIT_n), 32'(0));
    if (same) begin
      RSP_VALID = 1'b1; RSP_RDATA = d;
      step();
    end else begin
      step();
      RSP_VALID = 1'b1; RSP_RDATA = d;
      step();
    end
    RSP_VALID = 1'b0;
    chk("b2b_dout", 32'(BUS_DOUT), 32'(d));
    chk("b2b_wait_rel", 32'(BUS_WAIT_n), 32'(1));
    chk("b2b_busdir", 32'(BUS_BUSDIR_n), 32'(0));
    BUS_RD_n = 1'b1;
    step();
    chk("b2b_busdir_rel", 32'(BUS_BUSDIR_n), 32'(1));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "bench time limit");
  end

  initial begin
    RESET_n = 1'b0; bus_idle();
    REQ_READY = 1'b0; RSP_VALID = 1'b0; RSP_RDATA = 8'h00;
    #23;
    chk("rst_valid", 32'(REQ_VALID), 32'(0));
    chk("rst_wait", 32'(BUS_WAIT_n), 32'(1));
    chk("rst_busdir", 32'(BUS_BUSDIR_n), 32'(1));
    chk("rst_dout", 32'(BUS_DOUT), 32'(8'hFF));
    chk("rst_addr", 32'(REQ_ADDR), 32'(0));
    RESET_n = 1'b1;
    step(); step();

    // Memory read: READY after two cycles, response three cycles later
    BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_ADDR = 16'h4000; BUS_RD_n = 1'b0;
    q.push_back('{1'b0, 1'b0, 16'h4000, 8'h00});
    step();
    chk("mr_valid_rise", 32'(REQ_VALID), 32'(1));
    chk("mr_wait_low", 32'(BUS_WAIT_n), 32'(0));
    step();
    chk("mr_valid_hold", 32'(REQ_VALID), 32'(1));
    REQ_READY = 1'b1;
    step();
    REQ_READY = 1'b0;
    chk("mr_valid_drop", 32'(REQ_VALID), 32'(0));
    chk("mr_wait_rspw0", 32'(BUS_WAIT_n), 32'(0));
    step();
    chk("mr_wait_rspw1", 32'(BUS_WAIT_n), 32'(0));
    step();
    chk("mr_wait_rspw2", 32'(BUS_WAIT_n), 32'(0));
    RSP_VALID = 1'b1; RSP_RDATA = 8'hA5;
    step();
    RSP_VALID = 1'b0;
    chk("mr_dout", 32'(BUS_DOUT), 32'(8'hA5));
    chk("mr_wait_rel", 32'(BUS_WAIT_n), 32'(1));
    chk("mr_busdir", 32'(BUS_BUSDIR_n), 32'(0));
    step();
    chk("mr_busdir_hold", 32'(BUS_BUSDIR_n), 32'(0));
    BUS_RD_n = 1'b1;
    step();
    chk("mr_busdir_rel", 32'(BUS_BUSDIR_n), 32'(1));
    bus_idle();
    step();

    // I/O write with READY held low for five cycles
    BUS_IORQ_n = 1'b0; BUS_M1_n = 1'b1; BUS_ADDR = 16'h127D; BUS_DIN = 8'h3C; BUS_WR_n = 1'b0;
    q.push_back('{1'b1, 1'b1, 16'h127D, 8'h3C});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("iow_valid", 32'(REQ_VALID), 32'(1));
      chk("iow_wdata", 32'(REQ_WDATA), 32'(8'h3C));
      chk("iow_io", 32'(REQ_IO), 32'(1));
      chk("iow_addr", 32'(REQ_ADDR), 32'(16'h127D));
      chk("iow_wait", 32'(BUS_WAIT_n), 32'(1));
      chk("iow_busdir", 32'(BUS_BUSDIR_n), 32'(1));
    end
    REQ_READY = 1'b1;
    step();
    REQ_READY = 1'b0;
    chk("iow_valid_drop", 32'(REQ_VALID), 32'(0));
    BUS_WR_n = 1'b1;
    step();
    chk("iow_busdir_end", 32'(BUS_BUSDIR_n), 32'(1));
    chk("iow_wait_end", 32'(BUS_WAIT_n), 32'(1));
    bus_idle();
    step();

    // Filtered cycles: none may raise REQ_VALID
    REQ_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus_idle();
      case (c)
        0: begin BUS_IORQ_n = 1'b0; BUS_ADDR = 16'h007E; BUS_WR_n = 1'b0; end
        1: begin BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_RFSH_n = 1'b0; BUS_RD_n = 1'b0; end
        2: begin BUS_MERQ_n = 1'b0; BUS_RD_n = 1'b0; end
        3: begin BUS_IORQ_n = 1'b0; BUS_M1_n = 1'b0; BUS_ADDR = 16'h007C; BUS_RD_n = 1'b0; end
        default: begin BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_RD_n = 1'b0; BUS_WR_n = 1'b0; end
      endcase
      repeat (3) begin
        step();
        chk($sformatf("filt%0d_valid", c), 32'(REQ_VALID), 32'(0));
      end
      bus_idle();
      step(); step();
    end

    // Back-to-back reads, READY tied high; second response coincides with READY
    mem_read_fast(16'h8000, 8'h11, 1'b0);
    mem_read_fast(16'h8001, 8'h22, 1'b1);
    bus_idle();
    step();

    // Reset while waiting for a response
    BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_ADDR = 16'hC000; BUS_RD_n = 1'b0;
    q.push_back('{1'b0, 1'b0, 16'hC000, 8'h00});
    step(); step();
    REQ_READY = 1'b0;
    step();
    chk("rr_wait_pre", 32'(BUS_WAIT_n), 32'(0));
    #3 RESET_n = 1'b0;
    #1;
    chk("rr_wait", 32'(BUS_WAIT_n), 32'(1));
    chk("rr_valid", 32'(REQ_VALID), 32'(0));
    chk("rr_dout", 32'(BUS_DOUT), 32'(8'hFF));
    chk("rr_busdir", 32'(BUS_BUSDIR_n), 32'(1));
    bus_idle();
    step();
    RESET_n = 1'b1;
    step();
    RSP_VALID = 1'b1; RSP_RDATA = 8'h77;
    step();
    RSP_VALID = 1'b0;
    chk("rr_late_dout", 32'(BUS_DOUT), 32'(8'hFF));
    chk("rr_late_wait", 32'(BUS_WAIT_n), 32'(1));
    chk("rr_late_valid", 32'(REQ_VALID), 32'(0));
    step();

    // Read whose backend accepts but never answers on time
    REQ_READY = 1'b1;
    BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_ADDR = 16'h2000; BUS_RD_n = 1'b0;
    q.push_back('{1'b0, 1'b0, 16'h2000, 8'h00});
    step();
`ifdef MSX_BUS_TIMEOUT_EN
    k = 0;
    while (BUS_WAIT_n == 1'b0 && k < 100) begin
      step();
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'(16));
    chk("tmo_dout", 32'(BUS_DOUT), 32'(8'hFF));
    exp_dout = 8'hFF;
    BUS_RD_n = 1'b1;
    step();
`else
    k = 0;
    repeat (20) step();
    chk("notmo_wait", 32'(BUS_WAIT_n), 32'(0));
    chk("notmo_valid", 32'(REQ_VALID), 32'(0));
    RSP_VALID = 1'b1; RSP_RDATA = 8'h5A;
    step();
    RSP_VALID = 1'b0;
    chk("notmo_dout", 32'(BUS_DOUT), 32'(8'h5A));
    chk("notmo_wait_rel", 32'(BUS_WAIT_n), 32'(1));
    exp_dout = 8'h5A;
    BUS_RD_n = 1'b1;
    step();
`endif
    REQ_READY = 1'b0;
    bus_idle();
    step();

    // Bus abort: RD_n rises before the handshake; response must be discarded
    BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0; BUS_ADDR = 16'h4004; BUS_RD_n = 1'b0;
    q.push_back('{1'b0, 1'b0, 16'h4004, 8'h00});
    step();
    BUS_RD_n = 1'b1;
    step();
    chk("ab_wait", 32'(BUS_WAIT_n), 32'(1));
    chk("ab_valid_held", 32'(REQ_VALID), 32'(1));
    REQ_READY = 1'b1;
    step();
    REQ_READY = 1'b0;
    RSP_VALID = 1'b1; RSP_RDATA = 8'h99;
    step();
    RSP_VALID = 1'b0;
    chk("ab_dout", 32'(BUS_DOUT), 32'(exp_dout));
    chk("ab_busdir", 32'(BUS_BUSDIR_n), 32'(1));
    chk("ab_valid", 32'(REQ_VALID), 32'(0));
    bus_idle();
    step(); step();
    chk("q_empty", 32'(q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
